sipo_deframer: RTL and testbench

//  Downstream consumer of the registered serial bit from the D flip-flop stage.

---
 rtl/sipo_pkg.sv | 23 ++
 rtl/sipo_bit_counter.sv | 42 ++++
 rtl/sipo_deframer.sv | 160 ++++++++++++++++
 tb/tb_sipo_deframer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deframer: state encoding,
// WIDTH limits and the parity helper used when SIPO_PARITY_EN is defined.
package sipo_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_PAR   = 2'd2,
      S_HOLD  = 2'd3
   } state_e;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   // Widest possible data word plus its parity bit, zero-extended.
   typedef logic [WIDTH_MAX:0] par_vec_t;

   // Even-parity check: 1 when the vector holds an odd number of ones.
   function automatic logic par_err_f(input par_vec_t v);
      return ^v;
   endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit counter for the deframer: synchronous clear wins over increment, and
// `last` flags the final data bit of a frame (count == WIDTH-1).
module sipo_bit_counter #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rest,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear has priority, otherwise step on each accepted bit.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign last  = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/sipo_deframer.sv
// Framed serial-to-parallel deframer, LSB first, with valid/ready output and a
// sticky overrun flag. Define SIPO_PARITY_EN to add a trailing even-parity bit.
module sipo_deframer
   import sipo_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rest,
   input  logic             din,
   input  logic             din_en,
   input  logic             start,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic             valid_q, valid_d;
   logic             ovr_q,   ovr_d;
   logic             perr_q,  perr_d;
   logic             cnt_clr_s, cnt_inc_s, cnt_last_s;
   logic             step_s;
   logic [CNT_W-1:0] cnt_s;
   logic [WIDTH-1:0] shifted_s;

   assign shifted_s = {din, shreg_q[WIDTH-1:1]};

   sipo_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .rest  (rest),
      .clr   (cnt_clr_s),
      .inc   (cnt_inc_s),
      .count (cnt_s),
      .last  (cnt_last_s)
   );

   // Next-state, datapath and flag updates for the frame FSM.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      ovr_d     = ovr_q;
      perr_d    = perr_q;
      cnt_clr_s = 1'b0;
      step_s    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_SHIFT;
               shreg_d   = '0;
               cnt_clr_s = 1'b1;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_SHIFT: begin
            // A fresh start discards the partial word and beats any data bit.
            if (start) begin
               shreg_d   = '0;
               cnt_clr_s = 1'b1;
            end else if (din_en) begin
               shreg_d = shifted_s;
               step_s  = 1'b1;
               if (cnt_last_s) begin
`ifdef SIPO_PARITY_EN
                  state_d = S_PAR;
`else
                  state_d = S_HOLD;
                  data_d  = shifted_s;
`endif
               end else begin
                  state_d = S_SHIFT;
               end
            end else begin
               state_d = S_SHIFT;
            end
         end
`ifdef SIPO_PARITY_EN
         S_PAR: begin
            if (start) begin
               state_d   = S_SHIFT;
               shreg_d   = '0;
               cnt_clr_s = 1'b1;
            end else if (din_en) begin
               state_d = S_HOLD;
               data_d  = shreg_q;
               perr_d  = par_err_f(par_vec_t'({shreg_q, din}));
            end else begin
               state_d = S_PAR;
            end
         end
`endif
         S_HOLD: begin
            // Bits arriving while a word is held are dropped and recorded.
            if (din_en) begin
               ovr_d = 1'b1;
            end else begin
               ovr_d = ovr_q;
            end
            if (out_ready) begin
               perr_d = 1'b0;
               if (start) begin
                  state_d   = S_SHIFT;
                  shreg_d   = '0;
                  cnt_clr_s = 1'b1;
               end else begin
                  state_d   = S_IDLE;
               end
            end else begin
               state_d = S_HOLD;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      valid_d = (state_d == S_HOLD);
   end

   // Saturating guard keeps the counter inside its range even on a bad frame.
   assign cnt_inc_s = step_s && (cnt_s != CNT_W'(WIDTH));

   // State, shift register, output word and status flags.
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         perr_q  <= perr_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign overrun   = ovr_q;
   assign busy      = (state_q != S_IDLE);
`ifdef SIPO_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deframer.sv
// Self-checking bench for sipo_deframer: directed scenarios plus randomized
// frames checked against an arithmetic model of the LSB-first framing rules.
module tb_sipo_deframer;

   localparam int W = 8;
`ifdef SIPO_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif

   logic         clk = 1'b0;
   logic         rest, din, din_en, start, out_ready;
   logic [W-1:0] out_data;
   logic         out_valid, busy, overrun, parity_err;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   sipo_deframer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rest       (rest),
      .din        (din),
      .din_en     (din_en),
      .start      (start),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .busy       (busy),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      start = 1'b1; din_en = 1'b0; din = 1'($urandom);
      tick();
      start = 1'b0;
   endtask

   // Sends word v LSB first (plus a correct even-parity bit when enabled);
   // early reports whether out_valid was seen before the final bit.
   task automatic send_word(input int v, input bit gaps, output bit early);
      int b;
      early = 1'b0;
      for (int j = 0; j < NB; j++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               din = 1'($urandom); din_en = 1'b0;
               tick();
               early |= out_valid;
            end
         end
         b = (j < W) ? ((v >> j) & 1) : ($countones(v[W-1:0]) % 2);
         din = b[0]; din_en = 1'b1;
         tick();
         din_en = 1'b0;
         if (j != NB - 1) early |= out_valid;
      end
   endtask

   task automatic test_reset();
      rest = 1'b1; din = 1'b0; din_en = 1'b0; start = 1'b0; out_ready = 1'b0;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", parity_err); end
      rest = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      bit early;
      start_frame();
      for (int i = 0; i < 3; i++) begin
         din = 1'($urandom); din_en = 1'b1;
         tick();
      end
      din_en = 1'b0;
      rest = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_async got %b exp 0", busy); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
      rest = 1'b0;
      tick();
      start_frame();
      send_word(32'hA5, 1'b0, early);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("FAIL abort_refr got %b/%h exp 1/a5", out_valid, out_data); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b exp 0", busy); end
   endtask

   task automatic test_frame();
      bit early;
      start_frame();
      send_word(32'hA5, 1'b0, early);
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL frame_early got %b exp 0", early); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL frame_valid got %b exp 1", out_valid); end
      checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL frame_data got %h exp a5", out_data); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy got %b exp 1", busy); end
   endtask

   task automatic test_overrun();
      repeat (5) tick();
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (out_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL hold_stable got %b/%b exp 1/0", out_valid, overrun); end
      din = 1'b0; din_en = 1'b1; tick(); din_en = 1'b0;
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
      checks++; if (out_data !== 8'hA5 || out_valid !== 1'b1) begin errors++; $display("FAIL ovr_data got %h/%b exp a5/1", out_data, out_valid); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL ovr_hs got %b/%b exp 0/0", busy, out_valid); end
      checks++; if (out_data !== 8'hA5 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_keep got %h/%b exp a5/1", out_data, overrun); end
   endtask

   task automatic test_restart();
      bit early;
      start_frame();
      for (int i = 0; i < 4; i++) begin
         din = 1'($urandom); din_en = 1'b1;
         tick();
      end
      din_en = 1'b1; din = 1'b1; start = 1'b1; tick(); start = 1'b0; din_en = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rst_mid got %b/%b exp 0/1", out_valid, busy); end
      send_word(32'h3C, 1'b0, early);
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL restart_early got %b exp 0", early); end
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin errors++; $display("FAIL restart_data got %b/%h exp 1/3c", out_valid, out_data); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit early;
      start_frame();
      send_word(32'h5A, 1'b0, early);
      checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL b2b_first got %h exp 5a", out_data); end
      out_ready = 1'b1; start = 1'b1; tick(); out_ready = 1'b0; start = 1'b0;
      checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b/%b exp 1/0", busy, out_valid); end
      send_word(32'hFF, 1'b0, early);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin errors++; $display("FAIL b2b_second got %b/%h exp 1/ff", out_valid, out_data); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", busy); end
   endtask

`ifdef SIPO_PARITY_EN
   task automatic test_parity();
      logic [W-1:0] w;
      w = 8'h07;
      for (int p = 1; p >= 0; p--) begin
         start_frame();
         for (int j = 0; j < W; j++) begin
            din = w[j]; din_en = 1'b1; tick();
         end
         din = p[0]; din_en = 1'b1; tick(); din_en = 1'b0;
         checks++; if (out_valid !== 1'b1 || out_data !== 8'h07) begin errors++; $display("FAIL par_word got %b/%h exp 1/07", out_valid, out_data); end
         checks++; if (parity_err !== (p == 0)) begin errors++; $display("FAIL par_err got %b exp %b", parity_err, (p == 0)); end
         out_ready = 1'b1; tick(); out_ready = 1'b0;
         checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_clear got %b exp 0", parity_err); end
      end
   endtask
`endif

   task automatic test_random();
      bit early, pending, b2b;
      logic exp_ovr;
      int v;
      rest = 1'b1; tick(); rest = 1'b0; tick();
      exp_ovr = 1'b0;
      pending = 1'b0;
      for (int n = 0; n < 60; n++) begin
         if (!pending) start_frame();
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, W - 1)) begin
               din = 1'($urandom); din_en = 1'b1; tick();
            end
            din_en = 1'b0;
            start_frame();
         end
         v = int'($urandom_range(0, 255));
         send_word(v, 1'b1, early);
         checks++; if (early !== 1'b0) begin errors++; $display("FAIL rnd_early n=%0d got %b exp 0", n, early); end
         checks++; if (out_valid !== 1'b1 || out_data !== W'(v)) begin errors++; $display("FAIL rnd_word n=%0d got %b/%h exp 1/%h", n, out_valid, out_data, W'(v)); end
         checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rnd_perr n=%0d got %b exp 0", n, parity_err); end
         repeat ($urandom_range(0, 3)) begin
            din = 1'($urandom); din_en = ($urandom_range(0, 3) == 0); start = 1'($urandom);
            if (din_en) exp_ovr = 1'b1;
            tick();
            din_en = 1'b0; start = 1'b0;
            checks++; if (out_valid !== 1'b1 || out_data !== W'(v) || overrun !== exp_ovr) begin errors++; $display("FAIL rnd_hold n=%0d got %b/%h/%b exp 1/%h/%b", n, out_valid, out_data, overrun, W'(v), exp_ovr); end
         end
         b2b = 1'($urandom);
         out_ready = 1'b1; start = b2b; tick(); out_ready = 1'b0; start = 1'b0;
         checks++; if (busy !== b2b || out_valid !== 1'b0) begin errors++; $display("FAIL rnd_hs n=%0d got %b/%b exp %b/0", n, busy, out_valid, b2b); end
         pending = b2b;
      end
   endtask

   initial begin
      test_reset();
      test_abort();
      test_frame();
      test_overrun();
      test_restart();
      test_back_to_back();
`ifdef SIPO_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
